id_ex_stage: RTL and testbench

//  ID/EX pipeline register feeding the ALU. Captures decoded operands and control from ID.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/alu_ctrl_dec.sv | 35 +++
 rtl/id_ex_stage.sv | 186 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared ALU-control encodings, ALUOp/funct codes and pass-through control payload
// for the MIPS ID/EX datapath.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ORI   = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational {ALUOp, funct} -> {ALU control, illegal} translation.
module alu_ctrl_dec
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control_c,
  output logic       illegal_c
);

  always_comb begin
    alu_control_c = ALU_BAD;
    illegal_c     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control_c = ALU_ADD;
      ALUOP_SUB: alu_control_c = ALU_SUB;
      ALUOP_ORI: alu_control_c = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: alu_control_c = ALU_ADD;
          FUNCT_SUB: alu_control_c = ALU_SUB;
          FUNCT_AND: alu_control_c = ALU_AND;
          FUNCT_OR:  alu_control_c = ALU_OR;
          FUNCT_NOR: alu_control_c = ALU_NOR;
          FUNCT_SLT: alu_control_c = ALU_SLT;
          default: begin
            alu_control_c = ALU_BAD;
            illegal_c     = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, stall, flush and ALU-control decode.
// Optional operand bypass from EX/MEM and MEM/WB when FORWARDING_EN is defined.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [15:0]       in_imm16,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_wr_reg,
  input  logic [1:0]        in_alu_op,
  input  logic [5:0]        in_funct,
  input  logic              in_alu_src,
  input  logic [3:0]        in_ctrl,
  input  logic              flush,
`ifdef FORWARDING_EN
  input  logic              exmem_wr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [REG_AW-1:0] out_wr_reg,
  output logic [3:0]        out_ctrl,
  output logic              illegal_op
);

  localparam int unsigned IMM_W = 16;
  localparam int unsigned EXT_W = DATA_W - IMM_W;

  logic [3:0]        dec_ctrl_c;
  logic              dec_illegal_c;
  logic              capture_c;
  logic              use_imm_c;
  logic [DATA_W-1:0] imm_ext_c;

  logic              valid_q,    valid_d;
  logic              illegal_q,  illegal_d;
  logic [DATA_W-1:0] a_q,        a_d;
  logic [DATA_W-1:0] b_q,        b_d;
  logic [DATA_W-1:0] rt_data_q,  rt_data_d;
  logic [REG_AW-1:0] wr_reg_q,   wr_reg_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  ctrl_t             ctrl_q,     ctrl_d;
`ifdef FORWARDING_EN
  logic [REG_AW-1:0] rs_q,       rs_d;
  logic [REG_AW-1:0] rt_q,       rt_d;
  logic              use_imm_q,  use_imm_d;
`endif

  alu_ctrl_dec u_alu_ctrl_dec (
    .alu_op        (in_alu_op),
    .funct         (in_funct),
    .alu_control_c (dec_ctrl_c),
    .illegal_c     (dec_illegal_c)
  );

  assign in_ready  = ~valid_q | out_ready;
  assign capture_c = in_valid & in_ready & ~flush;
  assign use_imm_c = in_alu_src | (in_alu_op == ALUOP_ORI);
  // ori zero-extends its immediate; every other immediate form sign-extends
  assign imm_ext_c = (in_alu_op == ALUOP_ORI) ? {{EXT_W{1'b0}}, in_imm16}
                                              : {{EXT_W{in_imm16[IMM_W-1]}}, in_imm16};

  // Next-state: flush beats capture, capture beats drain, otherwise hold
  always_comb begin
    valid_d    = valid_q;
    illegal_d  = illegal_q;
    a_d        = a_q;
    b_d        = b_q;
    rt_data_d  = rt_data_q;
    wr_reg_d   = wr_reg_q;
    alu_ctrl_d = alu_ctrl_q;
    ctrl_d     = ctrl_q;
`ifdef FORWARDING_EN
    rs_d       = rs_q;
    rt_d       = rt_q;
    use_imm_d  = use_imm_q;
`endif
    if (flush) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (capture_c) begin
      valid_d    = 1'b1;
      illegal_d  = dec_illegal_c;
      a_d        = in_rs_data;
      b_d        = use_imm_c ? imm_ext_c : in_rt_data;
      rt_data_d  = in_rt_data;
      wr_reg_d   = in_wr_reg;
      alu_ctrl_d = dec_ctrl_c;
      ctrl_d     = ctrl_t'(in_ctrl);
`ifdef FORWARDING_EN
      rs_d       = in_rs;
      rt_d       = in_rt;
      use_imm_d  = use_imm_c;
`endif
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rt_data_q  <= '0;
      wr_reg_q   <= '0;
      alu_ctrl_q <= '0;
      ctrl_q     <= '0;
`ifdef FORWARDING_EN
      rs_q       <= '0;
      rt_q       <= '0;
      use_imm_q  <= 1'b0;
`endif
    end else begin
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rt_data_q  <= rt_data_d;
      wr_reg_q   <= wr_reg_d;
      alu_ctrl_q <= alu_ctrl_d;
      ctrl_q     <= ctrl_d;
`ifdef FORWARDING_EN
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      use_imm_q  <= use_imm_d;
`endif
    end
  end

`ifdef FORWARDING_EN
  logic [DATA_W-1:0] rs_fwd_c;
  logic [DATA_W-1:0] rt_fwd_c;

  // Youngest producer wins; $zero is hardwired and never bypassed
  always_comb begin
    rs_fwd_c = a_q;
    rt_fwd_c = rt_data_q;
    if (exmem_wr && (exmem_rd != REG_AW'(0)) && (exmem_rd == rs_q)) begin
      rs_fwd_c = exmem_data;
    end else if (memwb_wr && (memwb_rd != REG_AW'(0)) && (memwb_rd == rs_q)) begin
      rs_fwd_c = memwb_data;
    end
    if (exmem_wr && (exmem_rd != REG_AW'(0)) && (exmem_rd == rt_q)) begin
      rt_fwd_c = exmem_data;
    end else if (memwb_wr && (memwb_rd != REG_AW'(0)) && (memwb_rd == rt_q)) begin
      rt_fwd_c = memwb_data;
    end
  end

  assign operand_a   = rs_fwd_c;
  assign operand_b   = use_imm_q ? b_q : rt_fwd_c;
  assign out_rt_data = rt_fwd_c;
`else
  logic unused_c;
  assign unused_c    = ^{in_rs, in_rt};
  assign operand_a   = a_q;
  assign operand_b   = b_q;
  assign out_rt_data = rt_data_q;
`endif

  assign out_valid   = valid_q;
  assign alu_control = alu_ctrl_q;
  assign out_wr_reg  = wr_reg_q;
  assign out_ctrl    = ctrl_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: decode vector table, stall/flush/reset sequences, random run vs model.
module tb_id_ex_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_alu_src, flush, out_valid, out_ready, illegal_op;
  logic [DW-1:0] in_rs_data, in_rt_data, operand_a, operand_b, out_rt_data;
  logic [15:0]   in_imm16;
  logic [AW-1:0] in_rs, in_rt, in_wr_reg, out_wr_reg;
  logic [1:0]    in_alu_op;
  logic [5:0]    in_funct;
  logic [3:0]    in_ctrl, alu_control, out_ctrl;
`ifdef FORWARDING_EN
  logic          exmem_wr, memwb_wr;
  logic [AW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_data, memwb_data;
`endif

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm16(in_imm16),
    .in_rs(in_rs), .in_rt(in_rt), .in_wr_reg(in_wr_reg), .in_alu_op(in_alu_op),
    .in_funct(in_funct), .in_alu_src(in_alu_src), .in_ctrl(in_ctrl), .flush(flush),
`ifdef FORWARDING_EN
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .operand_a(operand_a),
    .operand_b(operand_b), .alu_control(alu_control), .out_rt_data(out_rt_data),
    .out_wr_reg(out_wr_reg), .out_ctrl(out_ctrl), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode straight from the ALUOp/funct table
  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
    logic [5:0] codes [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
    logic [3:0] res   [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd7};
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    if (op == 2'd3) return 4'd1;
    for (int i = 0; i < 6; i++) if (codes[i] == f) return res[i];
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_b(input logic [1:0] op, input logic src,
                                        input logic [15:0] imm, input logic [31:0] rt);
    if (op == 2'd3) return 32'(imm);
    if (src) return 32'(int'($signed(imm)));
    return rt;
  endfunction

  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic src,
                       input logic [15:0] imm, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [4:0] wr, input logic [3:0] c);
    in_alu_op = op; in_funct = f; in_alu_src = src; in_imm16 = imm;
    in_rs_data = rsd; in_rt_data = rtd; in_wr_reg = wr; in_ctrl = c;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic        src;
    logic [15:0] imm;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [3:0]  e_ctrl;
    logic [31:0] e_b;
    logic        e_ill;
  } vec_t;

  vec_t vt [13];

  // Model state for the random run
  logic        mv, mill;
  logic [31:0] ma, mb, mrt;
  logic [4:0]  mwr;
  logic [3:0]  mac, mc;

  initial begin
    vt[0]  = '{2'b10, 6'b101010, 1'b0, 16'h0000, 32'd5, 32'd9, 4'b0111, 32'd9, 1'b0};
    vt[1]  = '{2'b00, 6'b000000, 1'b1, 16'hFFFC, 32'd1, 32'd2, 4'b0010, 32'hFFFFFFFC, 1'b0};
    vt[2]  = '{2'b11, 6'b000000, 1'b1, 16'hFFFC, 32'd1, 32'd2, 4'b0001, 32'h0000FFFC, 1'b0};
    vt[3]  = '{2'b11, 6'b000000, 1'b0, 16'hFFFC, 32'd1, 32'd2, 4'b0001, 32'h0000FFFC, 1'b0};
    vt[4]  = '{2'b01, 6'b111111, 1'b0, 16'h8000, 32'd3, 32'h1234, 4'b0110, 32'h1234, 1'b0};
    vt[5]  = '{2'b10, 6'b100000, 1'b0, 16'h0000, 32'd7, 32'd8, 4'b0010, 32'd8, 1'b0};
    vt[6]  = '{2'b10, 6'b100010, 1'b0, 16'h0000, 32'd7, 32'd8, 4'b0110, 32'd8, 1'b0};
    vt[7]  = '{2'b10, 6'b100100, 1'b0, 16'h0000, 32'd7, 32'd8, 4'b0000, 32'd8, 1'b0};
    vt[8]  = '{2'b10, 6'b100101, 1'b0, 16'h0000, 32'd7, 32'd8, 4'b0001, 32'd8, 1'b0};
    vt[9]  = '{2'b10, 6'b100111, 1'b0, 16'h0000, 32'd7, 32'd8, 4'b1100, 32'd8, 1'b0};
    vt[10] = '{2'b10, 6'b000000, 1'b0, 16'h0000, 32'd7, 32'd8, 4'b1111, 32'd8, 1'b1};
    vt[11] = '{2'b00, 6'b000000, 1'b1, 16'h7FFF, 32'd7, 32'd8, 4'b0010, 32'h00007FFF, 1'b0};
    vt[12] = '{2'b10, 6'b101010, 1'b1, 16'h8000, 32'd7, 32'd8, 4'b0111, 32'hFFFF8000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_rs = '0; in_rt = '0;
    drive(2'b00, 6'd0, 1'b0, 16'd0, 32'd0, 32'd0, 5'd0, 4'd0);
`ifdef FORWARDING_EN
    exmem_wr = 1'b0; exmem_rd = '0; exmem_data = '0;
    memwb_wr = 1'b0; memwb_rd = '0; memwb_data = '0;
`endif
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ill", 32'(illegal_op), 32'd0);
    chk("rst_aluctrl", 32'(alu_control), 32'd0);
    chk("rst_opa", operand_a, 32'd0);
    chk("rst_opb", operand_b, 32'd0);
    chk("rst_rt", out_rt_data, 32'd0);
    chk("rst_wr", 32'(out_wr_reg), 32'd0);
    chk("rst_ctrl", 32'(out_ctrl), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Decode table, one instruction per cycle with downstream always ready
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].op, vt[i].f, vt[i].src, vt[i].imm, vt[i].rsd, vt[i].rtd, 5'(i + 1), 4'(i));
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_aluctrl", i), 32'(alu_control), 32'(vt[i].e_ctrl));
      chk($sformatf("vec%0d_opa", i), operand_a, vt[i].rsd);
      chk($sformatf("vec%0d_opb", i), operand_b, vt[i].e_b);
      chk($sformatf("vec%0d_ill", i), 32'(illegal_op), 32'(vt[i].e_ill));
      chk($sformatf("vec%0d_rt", i), out_rt_data, vt[i].rtd);
      chk($sformatf("vec%0d_wr", i), 32'(out_wr_reg), 32'(i + 1));
      chk($sformatf("vec%0d_ctrl", i), 32'(out_ctrl), 32'(i));
    end

    // Stall: A held three cycles while B waits, then B appears exactly once
    drive(2'b00, 6'd0, 1'b0, 16'd0, 32'd11, 32'd22, 5'd4, 4'hA);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("stall_a_valid", 32'(out_valid), 32'd1);
    drive(2'b01, 6'd0, 1'b0, 16'd0, 32'd33, 32'd44, 5'd6, 4'h5);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall%0d_ready", k), 32'(in_ready), 32'd0);
      tick();
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_opa", k), operand_a, 32'd11);
      chk($sformatf("stall%0d_wr", k), 32'(out_wr_reg), 32'd4);
      chk($sformatf("stall%0d_aluctrl", k), 32'(alu_control), 32'd2);
    end
    out_ready = 1'b1;
    #1 chk("release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("release_b_valid", 32'(out_valid), 32'd1);
    chk("release_b_opa", operand_a, 32'd33);
    chk("release_b_wr", 32'(out_wr_reg), 32'd6);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Flush kills the held illegal instruction and the incoming one
    drive(2'b10, 6'b000000, 1'b0, 16'd0, 32'd1, 32'd2, 5'd9, 4'd1);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("illegal_aluctrl", 32'(alu_control), 32'hF);
    chk("illegal_flag", 32'(illegal_op), 32'd1);
    out_ready = 1'b0; flush = 1'b1;
    drive(2'b00, 6'd0, 1'b0, 16'd0, 32'd5, 32'd6, 5'd3, 4'd2);
    tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ill", 32'(illegal_op), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush_dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset while stalled
    in_valid = 1'b1; out_ready = 1'b1;
    drive(2'b10, 6'b101010, 1'b0, 16'd0, 32'd5, 32'd9, 5'd2, 4'd3);
    tick();
    chk("prerst_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_aluctrl", 32'(alu_control), 32'd0);
    #1 rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);

`ifdef FORWARDING_EN
    // Bypass priority and $zero exclusion
    in_rs = 5'd3; in_rt = 5'd3; in_valid = 1'b1; out_ready = 1'b1;
    drive(2'b10, 6'b100000, 1'b0, 16'd0, 32'd100, 32'd55, 5'd1, 4'd0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    exmem_wr = 1'b1; exmem_rd = 5'd3; exmem_data = 32'd7;
    memwb_wr = 1'b1; memwb_rd = 5'd3; memwb_data = 32'd8;
    #1 chk("fwd_exmem_a", operand_a, 32'd7);
    chk("fwd_exmem_b", operand_b, 32'd7);
    exmem_wr = 1'b0;
    #1 chk("fwd_memwb_a", operand_a, 32'd8);
    out_ready = 1'b1; in_valid = 1'b1; in_rs = 5'd0; in_rt = 5'd0;
    exmem_wr = 1'b0; memwb_wr = 1'b0;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    exmem_wr = 1'b1; exmem_rd = 5'd0; memwb_wr = 1'b1; memwb_rd = 5'd0;
    #1 chk("fwd_zero_a", operand_a, 32'd100);
    chk("fwd_zero_rt", out_rt_data, 32'd55);
    exmem_wr = 1'b0; memwb_wr = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    in_rs = '0; in_rt = '0;
`endif

    // Random traffic against the transaction model
    mv = out_valid; mill = illegal_op;
    ma = '0; mb = '0; mrt = '0; mwr = '0; mac = '0; mc = '0;
    for (int n = 0; n < 400; n++) begin
      logic [1:0]  op;
      logic [5:0]  f;
      logic [15:0] imm;
      logic [31:0] rsd, rtd;
      logic        src, take;
      logic [5:0]  legal [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
      op  = 2'($urandom_range(0, 3));
      f   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 5)];
      imm = 16'($urandom);
      rsd = $urandom; rtd = $urandom;
      src = 1'($urandom);
      drive(op, f, src, imm, rsd, rtd, 5'($urandom), 4'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      #1;
      chk("rnd_ready", 32'(in_ready), 32'(!mv || out_ready));
      take = in_valid && (!mv || out_ready) && !flush;
      if (flush) begin
        mv = 1'b0; mill = 1'b0;
      end else if (take) begin
        mv = 1'b1;
        mac = ref_ctrl(op, f);
        mill = (mac == 4'hF);
        ma = rsd; mb = ref_b(op, src, imm, rtd); mrt = rtd;
        mwr = in_wr_reg; mc = in_ctrl;
      end else if (out_ready) begin
        mv = 1'b0;
      end
      tick();
      chk("rnd_valid", 32'(out_valid), 32'(mv));
      chk("rnd_ill", 32'(illegal_op), 32'(mill));
      if (mv) begin
        chk("rnd_aluctrl", 32'(alu_control), 32'(mac));
        chk("rnd_opa", operand_a, ma);
        chk("rnd_opb", operand_b, mb);
        chk("rnd_rt", out_rt_data, mrt);
        chk("rnd_wr", 32'(out_wr_reg), 32'(mwr));
        chk("rnd_ctrl", 32'(out_ctrl), 32'(mc));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
